// File: rtl/timer_cnt_core.sv
// -----------------------------------------------------------------------------
// timer_cnt_core
//
// Counting engine of the 8-bit timer IP. It sits behind the register block
// (TDR/TCR/TSR) and works from the decoded control fields.
//
// A prescaler turns sys_clk into a count strobe (tick) at /2, /4, /8 or /16.
// On each strobe the counter steps up or down. While load is high the counter
// follows tdr instead. Wrap-around sets a sticky overflow (FF->00) or
// underflow (00->FF) flag. Software clears the flags with one-cycle pulses.
//
// Optional feature (macro TIMER_CMP_EN):
//   When the macro is defined, the block gains a compare register input
//   (tcmp), a clear pulse (cmp_clr) and a sticky compare flag (cmp). cmp is
//   set on the edge where a load or a tick moves cnt to a value equal to tcmp.
//
// Ports:
//   sys_clk  in   system clock; all state on its rising edge
//   sys_rst  in   synchronous active-high reset
//   tdr      in   CNT_W  value loaded into the counter
//   load     in   level; counter follows tdr while high (highest priority)
//   updown   in   0 = count up, 1 = count down
//   en       in   count enable; 0 freezes cnt and clears the prescaler
//   cks      in   2    prescaler select: 00 /2, 01 /4, 10 /8, 11 /16
//   ovf_clr  in   one-cycle pulse, clears ovf (a same-cycle set wins)
//   udf_clr  in   one-cycle pulse, clears udf (a same-cycle set wins)
//   tcmp     in   CNT_W  compare value           (TIMER_CMP_EN only)
//   cmp_clr  in   one-cycle pulse, clears cmp    (TIMER_CMP_EN only)
//   cmp      out  sticky compare-match flag      (TIMER_CMP_EN only)
//   cnt      out  CNT_W  counter value (TCNT), registered
//   ovf      out  sticky overflow flag, registered
//   udf      out  sticky underflow flag, registered
//   tick     out  count strobe for the current cycle (combinational)
// -----------------------------------------------------------------------------
module timer_cnt_core #(
   parameter int CNT_W = 8,
   parameter int DIV_W = 4
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic [CNT_W-1:0] tdr,
   input  logic             load,
   input  logic             updown,
   input  logic             en,
   input  logic [1:0]       cks,
   input  logic             ovf_clr,
   input  logic             udf_clr,
`ifdef TIMER_CMP_EN
   input  logic [CNT_W-1:0] tcmp,
   input  logic             cmp_clr,
   output logic             cmp,
`endif
   output logic [CNT_W-1:0] cnt,
   output logic             ovf,
   output logic             udf,
   output logic             tick
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
   localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

   // ---------------------------------------------------------------------
   // Helper functions
   // ---------------------------------------------------------------------

   // Mask of prescaler bits [sel:0]. A tick fires when all of them are set.
   function automatic logic [DIV_W-1:0] div_mask(input logic [1:0] sel);
      logic [DIV_W-1:0] m;
      m = DIV_ZERO;
      for (int i = 0; i < DIV_W; i++) begin
         if (i <= int'(sel)) begin
            m[i] = 1'b1;
         end else begin
            m[i] = 1'b0;
         end
      end
      return m;
   endfunction

   // True when the counter value is at its top (all ones).
   function automatic logic cnt_is_max(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}});
   endfunction

   // True when the counter value is zero.
   function automatic logic cnt_is_zero(input logic [CNT_W-1:0] v);
      return (v == CNT_ZERO);
   endfunction

   // ---------------------------------------------------------------------
   // State and next-state signals
   // ---------------------------------------------------------------------
   logic [DIV_W-1:0] div_r;
   logic [DIV_W-1:0] div_nxt_s;
   logic [DIV_W-1:0] mask_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             ovf_r;
   logic             udf_r;
   logic             ovf_set_s;
   logic             udf_set_s;
   logic             ovf_nxt_s;
   logic             udf_nxt_s;
   logic             tick_s;
`ifdef TIMER_CMP_EN
   logic             cmp_r;
   logic             cmp_set_s;
   logic             cmp_nxt_s;
`endif

   // Count strobe. It is forced low during reset so that no strobe is seen
   // in a reset cycle. The low cks+1 prescaler bits must all be set.
   always_comb begin
      mask_s = div_mask(cks);
      if (sys_rst) begin
         tick_s = 1'b0;
      end else begin
         tick_s = en & ~load & ((div_r & mask_s) == mask_s);
      end
   end

   // Prescaler next state. It restarts from 0 whenever counting is not
   // active, so the first tick after enable comes a full period later.
   // A cks change does not restart the prescaler.
   always_comb begin
      div_nxt_s = div_r;
      if (!en || load) begin
         div_nxt_s = DIV_ZERO;
      end else begin
         div_nxt_s = div_r + DIV_ONE;
      end
   end

   // Counter next state. Priority: load, then tick, then hold.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (load) begin
         cnt_nxt_s = tdr;
      end else if (tick_s) begin
         case (updown)
            1'b0:    cnt_nxt_s = cnt_r + CNT_ONE;
            1'b1:    cnt_nxt_s = cnt_r - CNT_ONE;
            default: cnt_nxt_s = cnt_r;
         endcase
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // Wrap detection and sticky flag update. A set beats a same-cycle clear.
   // load and en do not touch the flags.
   always_comb begin
      ovf_set_s = tick_s & ~updown & cnt_is_max(cnt_r);
      udf_set_s = tick_s &  updown & cnt_is_zero(cnt_r);
      ovf_nxt_s = ovf_r;
      udf_nxt_s = udf_r;
      if (ovf_set_s) begin
         ovf_nxt_s = 1'b1;
      end else if (ovf_clr) begin
         ovf_nxt_s = 1'b0;
      end else begin
         ovf_nxt_s = ovf_r;
      end
      if (udf_set_s) begin
         udf_nxt_s = 1'b1;
      end else if (udf_clr) begin
         udf_nxt_s = 1'b0;
      end else begin
         udf_nxt_s = udf_r;
      end
   end

`ifdef TIMER_CMP_EN
   // Compare match. Only an actual update of cnt (by load or tick) can set
   // the flag. A value that just sits equal to tcmp does not set it again.
   always_comb begin
      cmp_set_s = (load | tick_s) & (cnt_nxt_s == tcmp);
      cmp_nxt_s = cmp_r;
      if (cmp_set_s) begin
         cmp_nxt_s = 1'b1;
      end else if (cmp_clr) begin
         cmp_nxt_s = 1'b0;
      end else begin
         cmp_nxt_s = cmp_r;
      end
   end
`endif

   // State registers with synchronous reset. A reset mid-count leaves no
   // prescaler phase behind.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         div_r <= DIV_ZERO;
         cnt_r <= CNT_ZERO;
         ovf_r <= 1'b0;
         udf_r <= 1'b0;
      end else begin
         div_r <= div_nxt_s;
         cnt_r <= cnt_nxt_s;
         ovf_r <= ovf_nxt_s;
         udf_r <= udf_nxt_s;
      end
   end

`ifdef TIMER_CMP_EN
   // Compare flag register.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cmp_r <= 1'b0;
      end else begin
         cmp_r <= cmp_nxt_s;
      end
   end

   assign cmp = cmp_r;
`endif

   assign cnt  = cnt_r;
   assign ovf  = ovf_r;
   assign udf  = udf_r;
   assign tick = tick_s;

endmodule

// File: doc/timer_cnt_core.md
Name: timer_cnt_core

Overview:
- Counting engine of the 8-bit timer IP. It sits directly downstream of the register block (TDR/TCR/TSR) and consumes its decoded control fields.
- Generates the internal count tick from sys_clk according to cks: pclk/2, /4, /8 or /16.
- Loads, increments and decrements the counter.
- Raises sticky overflow/underflow flags, which the register block reflects in TSR and clears by software.

Parameters:
- CNT_W, 8, counter and TDR width in bits.
- DIV_W, 4, prescaler width; supports divide ratios 2..2^DIV_W.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- tdr  in  CNT_W  TDR value to be loaded.
- load  in  1  TCR[7]; level, counter follows tdr while high.
- updown  in  1  TCR[5]; 0 = count up, 1 = count down.
- en  in  1  TCR[4]; count enable.
- cks  in  2  TCR[1:0]; 00 = /2, 01 = /4, 10 = /8, 11 = /16.
- ovf_clr  in  1  one-cycle pulse from the TSR write-0 decode; clears ovf.
- udf_clr  in  1  one-cycle pulse; clears udf.
- cnt  out  CNT_W  current counter value (TCNT).
- ovf  out  1  sticky overflow flag (TSR[0]).
- udf  out  1  sticky underflow flag (TSR[1]).
- tick  out  1  registered-domain count strobe, for debug and coverage.

Behaviour:
- Reset: synchronous, while sys_rst = 1 on a rising edge.
  - cnt, ovf, udf and the prescaler div all become 0.
  - tick = 0.
  - Reset mid-count aborts the count with no residual state.
- Prescaler:
  - div is a DIV_W-bit register. It is cleared when en = 0 or load = 1; otherwise it increments every cycle and wraps.
  - tick is combinational: tick = en & ~load & (div[cks:0] all ones).
  - Result: one tick every 2/4/8/16 cycles. The first tick falls 2/4/8/16 cycles after en rises, with div starting at 0.
- Changing cks while counting: div is not cleared; the new mask applies from the next cycle.
- Counter, with priority load > tick > hold:
  - load = 1: cnt <= tdr.
  - tick and updown = 0: cnt <= cnt + 1, modulo 2^CNT_W.
  - tick and updown = 1: cnt <= cnt - 1, modulo 2^CNT_W.
  - Otherwise cnt holds. In particular, en = 0 freezes cnt.
- Flags:
  - ovf set condition: tick & ~updown & cnt == all-ones (wrap FF→00).
  - udf set condition: tick & updown & cnt == 0 (wrap 00→FF).
  - Each flag is registered on the same edge as the wrap, so it is visible together with the wrapped cnt value.
  - Flags are sticky until their clr pulse.
  - Set and clr in the same cycle: set wins.
  - Flags are unaffected by load or by en dropping.
- Latency, counting up from load value V with cks = 00: ovf = 1 exactly (2^CNT_W − 1 − V)·2 + 2 cycles after the first cycle with en = 1 and load = 0. For the /2^(k+1) ratio, replace the factor 2 with 2^(k+1).
- No combinational path from any input to cnt, ovf or udf.

Optional Feature:
- Macro: TIMER_CMP_EN.
- Defined:
  - Adds input tcmp[CNT_W] and output cmp.
  - cmp is a sticky flag, set on the edge where cnt is updated, by tick or load, to a value equal to tcmp.
  - cmp is cleared by added input cmp_clr; set wins over clear.
  - cmp resets to 0.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset: drive arbitrary inputs with sys_rst = 1 for 1 cycle → cnt = 0x00, ovf = 0, udf = 0, tick = 0 on the next cycle.
- Up-count overflow: tdr = 0xF0, load 1 cycle, then en = 1, updown = 0, cks = 00 → ovf = 0 at cycle 31, ovf = 1 at cycle 32, cnt = 0x00 at cycle 32.
- Reset then recount:
  - First run: tdr = 0x80 up /2; wait 128 cycles, then pulse sys_rst → cnt = 0, ovf = 0.
  - Second run: reload 0x40 → ovf = 0 at cycle 192, ovf = 1 at cycle 384.
- Down-count underflow: tdr = 0x03, updown = 1, cks = 01 → udf = 1 after 16 cycles with cnt = 0xFF; ovf stays 0.
- Flag priority: hold ovf = 1, then pulse ovf_clr on the cycle of a new FF→00 wrap → ovf remains 1. A lone ovf_clr pulse → ovf = 0 on the next cycle.
- Enable freeze and cks switch:
  - Count up from 0x10 with cks = 11; drop en at cnt = 0x12 for 50 cycles → cnt holds at 0x12.
  - Re-enable → next increment occurs 16 cycles later.
  - With TIMER_CMP_EN and tcmp = 0x14 → cmp = 1 on the edge where cnt becomes 0x14.
